// File: rtl/cop_spi_master_if.sv
// Host-side request/response bundle for the coprocessor SPI master.
// The master modport is the requesting logic; the slave modport is the SPI engine.
interface cop_spi_master_if #(
    parameter int DEV_SELECT_WIDTH = 3,
    parameter int BYTE_WIDTH       = 8
);
    logic                        start;
    logic [DEV_SELECT_WIDTH-1:0] dev_select;
    logic [BYTE_WIDTH-1:0]       tx_data;
    logic                        hold;
    logic                        rls;
    logic                        busy;
    logic                        done;
    logic [BYTE_WIDTH-1:0]       rx_data;

    modport master (
        output start, dev_select, tx_data, hold, rls,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, dev_select, tx_data, hold, rls,
        output busy, done, rx_data
    );
endinterface

// File: rtl/cop_spi_master.sv
// Mode-0 SPI master for the coprocessor bus with an encoded device select.
// Define COP_SPI_MSB_FIRST_EN for MSB-first shifting; LSB-first otherwise.
module cop_spi_master #(
    parameter int DEV_SELECT_WIDTH = 3,
    parameter int BYTE_WIDTH       = 8,
    parameter int CLK_DIV          = 2,
    parameter logic [DEV_SELECT_WIDTH-1:0] IDLE_SELECT = '1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    cop_spi_master_if.slave             io_bus,
    output logic [DEV_SELECT_WIDTH-1:0] o_cop_nss,
    output logic                        o_cop_sck,
    output logic                        o_cop_mosi,
    input  logic                        i_cop_miso
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam int CW = $clog2(BYTE_WIDTH) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BYTE_WIDTH);
    localparam logic [CW-1:0] BIT_ONE  = CW'(1);

    typedef logic [BYTE_WIDTH-1:0] byte_t;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HELD, S_GAP} state_t;

`ifdef COP_SPI_MSB_FIRST_EN
    function automatic byte_t f_tx_shift(input byte_t d);
        return {d[BYTE_WIDTH-2:0], 1'b0};
    endfunction
    function automatic logic f_head(input byte_t d);
        return d[BYTE_WIDTH-1];
    endfunction
    function automatic byte_t f_rx_shift(input byte_t d, input logic b);
        return {d[BYTE_WIDTH-2:0], b};
    endfunction
`else
    function automatic byte_t f_tx_shift(input byte_t d);
        return {1'b0, d[BYTE_WIDTH-1:1]};
    endfunction
    function automatic logic f_head(input byte_t d);
        return d[0];
    endfunction
    function automatic byte_t f_rx_shift(input byte_t d, input logic b);
        return {b, d[BYTE_WIDTH-1:1]};
    endfunction
`endif

    state_t                      r_state, w_state;
    logic [DW-1:0]               r_div, w_div;
    logic [CW-1:0]               r_bit, w_bit;
    logic                        r_sck, w_sck;
    logic                        r_mosi, w_mosi;
    logic [DEV_SELECT_WIDTH-1:0] r_nss, w_nss;
    logic                        r_done, w_done;
    logic                        r_hold, w_hold;
    byte_t                       r_tx, w_tx;
    byte_t                       r_rx_sh, w_rx_sh;
    byte_t                       r_rx, w_rx;
    logic                        w_div_end;

    assign w_div_end = (r_div == DIV_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_nss   <= IDLE_SELECT;
            r_done  <= 1'b0;
            r_hold  <= 1'b0;
            r_tx    <= '0;
            r_rx_sh <= '0;
            r_rx    <= '0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_sck   <= w_sck;
            r_mosi  <= w_mosi;
            r_nss   <= w_nss;
            r_done  <= w_done;
            r_hold  <= w_hold;
            r_tx    <= w_tx;
            r_rx_sh <= w_rx_sh;
            r_rx    <= w_rx;
        end
    end

    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_sck   = r_sck;
        w_mosi  = r_mosi;
        w_nss   = r_nss;
        w_done  = 1'b0;
        w_hold  = r_hold;
        w_tx    = r_tx;
        w_rx_sh = r_rx_sh;
        w_rx    = r_rx;
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_state = S_SETUP;
                    w_div   = '0;
                    w_bit   = '0;
                    w_nss   = io_bus.dev_select;
                    w_tx    = io_bus.tx_data;
                    w_mosi  = f_head(io_bus.tx_data);
                    w_hold  = io_bus.hold;
                end
            end
            S_SETUP: begin
                if (w_div_end) begin
                    w_state = S_SHIFT;
                    w_div   = '0;
                    w_sck   = 1'b1;
                    w_rx_sh = f_rx_shift(r_rx_sh, i_cop_miso);
                end else begin
                    w_div = r_div + DIV_ONE;
                end
            end
            S_SHIFT: begin
                if (!w_div_end) begin
                    w_div = r_div + DIV_ONE;
                end else begin
                    w_div = '0;
                    if (r_sck) begin
                        w_sck  = 1'b0;
                        w_bit  = r_bit + BIT_ONE;
                        w_tx   = f_tx_shift(r_tx);
                        w_mosi = f_head(f_tx_shift(r_tx));
                    end else if (r_bit == BIT_LAST) begin
                        // Final low half-period is over: publish the byte.
                        w_done = 1'b1;
                        w_rx   = r_rx_sh;
                        if (r_hold) begin
                            w_state = S_HELD;
                        end else begin
                            w_state = S_GAP;
                            w_nss   = IDLE_SELECT;
                        end
                    end else begin
                        w_sck   = 1'b1;
                        w_rx_sh = f_rx_shift(r_rx_sh, i_cop_miso);
                    end
                end
            end
            S_HELD: begin
                // Release has priority; the held device code is reused.
                if (io_bus.rls) begin
                    w_state = S_GAP;
                    w_div   = '0;
                    w_nss   = IDLE_SELECT;
                end else if (io_bus.start) begin
                    w_state = S_SETUP;
                    w_div   = '0;
                    w_bit   = '0;
                    w_tx    = io_bus.tx_data;
                    w_mosi  = f_head(io_bus.tx_data);
                    w_hold  = io_bus.hold;
                end
            end
            S_GAP: begin
                if (w_div_end) begin
                    w_state = S_IDLE;
                end else begin
                    w_div = r_div + DIV_ONE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign io_bus.busy    = (r_state == S_SETUP) || (r_state == S_SHIFT) ||
                            (r_state == S_GAP);
    assign io_bus.done    = r_done;
    assign io_bus.rx_data = r_rx;
    assign o_cop_nss      = r_nss;
    assign o_cop_sck      = r_sck;
    assign o_cop_mosi     = r_mosi;
endmodule
